// File: rtl/nibble_uart_tx_if.sv
// FIFO read-side handshake: first-word-fall-through head entry plus pop strobe.
// master = FIFO read port, slave = consumer that pops entries.
interface nibble_uart_tx_if;
  logic       rd_empty;
  logic [3:0] rd_data;
  logic       rd_inc;

  modport master (output rd_empty, output rd_data, input rd_inc);
  modport slave  (input rd_empty, input rd_data, output rd_inc);
endinterface

// File: rtl/nibble_uart_tx.sv
// Pops two nibbles (low then high) from a FWFT FIFO and sends the byte as UART 8N1, LSB first.
// Optional even parity bit between data and stop when NIBBLE_UART_PARITY_EN is defined.
module nibble_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned POP_GAP      = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  nibble_uart_tx_if.slave fifo,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_frame_done,
  output logic            o_lo_pending
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    GAP_LO,
    FETCH_HI,
    GAP_HI,
    START,
    DATA,
    STOP
`ifdef NIBBLE_UART_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [3:0]         r_lo;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_rd_inc;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_lo_pending;
`ifdef NIBBLE_UART_PARITY_EN
  logic               r_par;
`endif

  logic w_bit_end;
  logic w_fd_next;
  logic w_gap_end;

  assign w_bit_end = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // frame_done is registered, so it is armed one cycle before the last stop cycle
  assign w_fd_next = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 2));
  assign w_gap_end = (r_gap_cnt == GAP_W'(POP_GAP - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_gap_cnt    <= '0;
      r_lo         <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_rd_inc     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_lo_pending <= 1'b0;
`ifdef NIBBLE_UART_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_rd_inc     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!fifo.rd_empty) begin
            r_rd_inc     <= 1'b1;
            r_lo         <= fifo.rd_data;
            r_busy       <= 1'b1;
            r_lo_pending <= 1'b1;
            r_gap_cnt    <= '0;
            r_state      <= GAP_LO;
          end
        end
        // rd_empty is not trusted until the FIFO has had POP_GAP cycles to update it
        GAP_LO: begin
          if (w_gap_end) begin
            r_gap_cnt <= '0;
            r_state   <= FETCH_HI;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        FETCH_HI: begin
          if (!fifo.rd_empty) begin
            r_rd_inc     <= 1'b1;
            r_shift      <= {fifo.rd_data, r_lo};
`ifdef NIBBLE_UART_PARITY_EN
            r_par        <= ^{fifo.rd_data, r_lo};
`endif
            r_lo_pending <= 1'b0;
            r_gap_cnt    <= '0;
            r_state      <= GAP_HI;
          end
        end
        GAP_HI: begin
          if (w_gap_end) begin
            r_gap_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_state   <= START;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == IDX_W'(7)) begin
`ifdef NIBBLE_UART_PARITY_EN
              r_tx    <= r_par;
              r_state <= PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
`ifdef NIBBLE_UART_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_fd_next) begin
              r_frame_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_tx         <= 1'b1;
          r_busy       <= 1'b0;
          r_lo_pending <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.rd_inc  = r_rd_inc;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_lo_pending = r_lo_pending;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Directed bench for nibble_uart_tx: FWFT FIFO model on the falling edge, UART frame checker.
module tb_nibble_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned GAP = 3;
`ifdef NIBBLE_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;
  logic frame_done;
  logic lo_pending;

  int total = 0;
  int bad   = 0;

  logic [3:0] q[$];
  int cyc       = 0;
  int pops      = 0;
  int last_pop  = -1000;
  int min_space = 1000;

  always #5 clk = ~clk;

  nibble_uart_tx_if fifo ();

  nibble_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .POP_GAP     (GAP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .fifo        (fifo),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_lo_pending(lo_pending)
  );

  // FWFT FIFO model: pops on each cycle where rd_inc is high, head/empty refreshed mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (fifo.rd_inc === 1'b1) begin
      pops++;
      if (cyc - last_pop < min_space) min_space = cyc - last_pop;
      last_pop = cyc;
      if (q.size() > 0) void'(q.pop_front());
    end
    fifo.rd_empty = (q.size() == 0);
    fifo.rd_data  = (q.size() > 0) ? q[0] : 4'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit and checks every cycle of the frame plus the idle cycle after it
  task automatic recv(input logic [7:0] exp, input string tag);
    int   n;
    int   fd_bad;
    logic want;
    logic stable;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(tx === 1'b0), 1);
    if (tx !== 1'b0) return;
    fd_bad = 0;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)              want = 1'b0;
      else if (b <= 8)         want = exp[b-1];
      else if (b == NBITS - 1) want = 1'b1;
      else                     want = ^exp;
      stable = 1'b1;
      for (int c = 0; c < int'(CPB); c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx !== want) stable = 1'b0;
        if (frame_done !== ((b == NBITS - 1) && (c == int'(CPB) - 1))) fd_bad++;
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(stable), 1);
    end
    check({tag, "_frame_done"}, fd_bad, 0);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_tx_idle_after"}, 32'(tx), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    int bad_cyc;

    // reset held with data already waiting
    q.push_back(4'h5);
    q.push_back(4'hA);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_tx_%0d", i), 32'(tx), 1);
      check($sformatf("rst_rd_inc_%0d", i), 32'(fifo.rd_inc), 0);
      check($sformatf("rst_busy_%0d", i), 32'(busy), 0);
      check($sformatf("rst_lo_pending_%0d", i), 32'(lo_pending), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_pop_rd_inc", 32'(fifo.rd_inc), 1);
    check("first_pop_busy", 32'(busy), 1);
    check("first_pop_lo_pending", 32'(lo_pending), 1);

    // single byte 0xA5
    recv(8'hA5, "single");
    check("single_pops", pops, 2);

    // starved high nibble
    q.push_back(4'h3);
    n = 0;
    while (lo_pending !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("starve_lo_pending_seen", 32'(lo_pending), 1);
    bad_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lo_pending !== 1'b1 || tx !== 1'b1 || busy !== 1'b1) bad_cyc++;
    end
    check("starve_wait_levels", bad_cyc, 0);
    q.push_back(4'hC);
    recv(8'hC3, "starved");
    check("starved_pops", pops, 4);

    // back-to-back frames from a preloaded FIFO
    p0 = pops;
    for (int i = 1; i <= 6; i++) q.push_back(4'(i));
    recv(8'h21, "b2b0");
    @(negedge clk);
    check("b2b0_busy_regain", 32'(busy), 1);
    recv(8'h43, "b2b1");
    @(negedge clk);
    check("b2b1_busy_regain", 32'(busy), 1);
    recv(8'h65, "b2b2");
    check("b2b_pops", pops - p0, 6);

    // reset during data bit 3 of 0x21
    p0 = pops;
    q.push_back(4'h1);
    q.push_back(4'h2);
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("midrst_start_seen", 32'(tx), 0);
    repeat (17) @(negedge clk);
    check("midrst_bit3_level", 32'(tx), 0);
    check("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_lo_pending", 32'(lo_pending), 0);
    check("midrst_frame_done", 32'(frame_done), 0);
    check("midrst_pops", pops - p0, 2);
    @(negedge clk);
    rst = 1'b0;
    bad_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo.rd_inc !== 1'b0) bad_cyc++;
    end
    check("midrst_quiet_after", bad_cyc, 0);
    check("midrst_no_repop", pops - p0, 2);
    q.push_back(4'h4);
    q.push_back(4'h8);
    recv(8'h84, "after_rst");
    check("after_rst_pops", pops - p0, 4);

    // parity cases (plain 8N1 frames when parity is not built in)
    q.push_back(4'h7);
    q.push_back(4'h0);
    recv(8'h07, "par07");
    q.push_back(4'h3);
    q.push_back(4'h0);
    recv(8'h03, "par03");

    check("pop_spacing", 32'(min_space >= int'(GAP) + 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
